// File: rtl/mux_pkg.sv
// Shared definitions for the arbitrating channel multiplexer: mode encodings
// and the select-width helper.
package mux_pkg;

   localparam int MODE_SEL  = 0;
   localparam int MODE_PRIO = 1;
   localparam int MODE_RR   = 2;

   // A select port is never narrower than one bit, even for tiny channel counts.
   function automatic int sel_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Circular-priority arbiter: searches the request vector upward from ptr,
// wrapping at NCH-1, and returns a one-hot grant plus its encoded index.
module rr_arbiter
   import mux_pkg::*;
#(
   parameter int NCH  = 4,
   parameter int SELW = 2
) (
   input  logic [NCH-1:0]  req,
   input  logic [SELW-1:0] ptr,
   input  logic            open,
   output logic [NCH-1:0]  grant,
   output logic [SELW-1:0] idx
);

   localparam logic [SELW:0] NCH_W = (SELW+1)'(NCH);

   logic [SELW:0]   pos;
   logic [SELW-1:0] c;
   logic            found;

   // ptr is always below NCH, so a single subtraction folds the wrap.
   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      pos   = '0;
      c     = '0;
      for (int off = 0; off < NCH; off++) begin
         pos = {1'b0, ptr} + (SELW+1)'(off);
         if (pos >= NCH_W) begin
            pos = pos - NCH_W;
         end
         c = pos[SELW-1:0];
         if (open && !found && req[c]) begin
            found    = 1'b1;
            grant[c] = 1'b1;
            idx      = c;
         end
      end
   end

endmodule

// File: rtl/arb_mux.sv
// N-channel to one valid/ready multiplexer with a single output register;
// channel choice is explicit select, fixed priority or round-robin.
module arb_mux
   import mux_pkg::*;
#(
   parameter int  WIDTH = 32,
   parameter int  NCH   = 4,
   parameter int  MODE  = MODE_SEL,
   localparam int SELW  = sel_width(NCH)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NCH-1:0]       in_valid,
   output logic [NCH-1:0]       in_ready,
   input  logic [NCH*WIDTH-1:0] in_data,
   input  logic [SELW-1:0]      sel,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH-1:0]     out_data,
   output logic [SELW-1:0]      out_ch,
   output logic                 err_sel
);

   localparam logic [SELW:0]   NCH_W = (SELW+1)'(NCH);
   localparam logic [SELW-1:0] LAST  = SELW'(NCH-1);

   logic             open;
   logic             sel_oor;
   logic [SELW-1:0]  rr_ptr;
   logic [SELW-1:0]  arb_ptr;
   logic [SELW-1:0]  grant_idx;
   logic [NCH-1:0]   req_sel;
   logic [NCH-1:0]   arb_req;
   logic [NCH-1:0]   grant;
   logic [WIDTH-1:0] ch_data [NCH];

   assign open    = !out_valid || out_ready;
   assign sel_oor = {1'b0, sel} >= NCH_W;

   // An out-of-range select matches no channel, so it yields no request.
   generate
      for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
         assign req_sel[gi] = in_valid[gi] && (sel == SELW'(gi));
         assign ch_data[gi] = in_data[gi*WIDTH +: WIDTH];
      end
   endgenerate

   always_comb begin
      arb_req = in_valid;
      arb_ptr = rr_ptr;
      if (MODE == MODE_SEL) begin
         arb_req = req_sel;
         arb_ptr = '0;
      end else if (MODE == MODE_PRIO) begin
         arb_ptr = '0;
      end
   end

   rr_arbiter #(
      .NCH  (NCH),
      .SELW (SELW)
   ) u_arb (
      .req   (arb_req),
      .ptr   (arb_ptr),
      .open  (open),
      .grant (grant),
      .idx   (grant_idx)
   );

   assign in_ready = reset ? '0 : grant;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ch    <= '0;
         err_sel   <= 1'b0;
         rr_ptr    <= '0;
      end else begin
         err_sel <= (MODE == MODE_SEL) && open && sel_oor;
         if (|grant) begin
            out_data  <= ch_data[grant_idx];
            out_ch    <= grant_idx;
            out_valid <= 1'b1;
            rr_ptr    <= (grant_idx == LAST) ? '0 : grant_idx + 1'b1;
         end else if (open) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_arb_mux.sv
// Bench for arb_mux: five configurations share one stimulus bus and are
// checked against a per-instance behavioural model of the arbitration rules.
module tb_arb_mux;

   logic         clk = 1'b0;
   logic         reset;
   logic [4:0]   vin;
   logic [2:0]   sel;
   logic         rdy;
   logic [159:0] din;

   always #5 clk = ~clk;

   // instance 0: MODE0 NCH4, 1: MODE0 NCH3, 2: MODE1 NCH4, 3: MODE2 NCH4, 4: MODE2 NCH5
   logic [3:0] r0; logic v0; logic [31:0] d0; logic [1:0] c0; logic e0;
   logic [2:0] r1; logic v1; logic [31:0] d1; logic [1:0] c1; logic e1;
   logic [3:0] r2; logic v2; logic [31:0] d2; logic [1:0] c2; logic e2;
   logic [3:0] r3; logic v3; logic [31:0] d3; logic [1:0] c3; logic e3;
   logic [4:0] r4; logic v4; logic [31:0] d4; logic [2:0] c4; logic e4;

   arb_mux #(.WIDTH(32), .NCH(4), .MODE(0)) u_sel4 (
      .clk(clk), .reset(reset), .in_valid(vin[3:0]), .in_ready(r0), .in_data(din[127:0]),
      .sel(sel[1:0]), .out_valid(v0), .out_ready(rdy), .out_data(d0), .out_ch(c0), .err_sel(e0));
   arb_mux #(.WIDTH(32), .NCH(3), .MODE(0)) u_sel3 (
      .clk(clk), .reset(reset), .in_valid(vin[2:0]), .in_ready(r1), .in_data(din[95:0]),
      .sel(sel[1:0]), .out_valid(v1), .out_ready(rdy), .out_data(d1), .out_ch(c1), .err_sel(e1));
   arb_mux #(.WIDTH(32), .NCH(4), .MODE(1)) u_prio (
      .clk(clk), .reset(reset), .in_valid(vin[3:0]), .in_ready(r2), .in_data(din[127:0]),
      .sel(sel[1:0]), .out_valid(v2), .out_ready(rdy), .out_data(d2), .out_ch(c2), .err_sel(e2));
   arb_mux #(.WIDTH(32), .NCH(4), .MODE(2)) u_rr4 (
      .clk(clk), .reset(reset), .in_valid(vin[3:0]), .in_ready(r3), .in_data(din[127:0]),
      .sel(sel[1:0]), .out_valid(v3), .out_ready(rdy), .out_data(d3), .out_ch(c3), .err_sel(e3));
   arb_mux #(.WIDTH(32), .NCH(5), .MODE(2)) u_rr5 (
      .clk(clk), .reset(reset), .in_valid(vin), .in_ready(r4), .in_data(din),
      .sel(sel), .out_valid(v4), .out_ready(rdy), .out_data(d4), .out_ch(c4), .err_sel(e4));

   logic [4:0]  o_rdy [5];
   logic        o_val [5];
   logic [31:0] o_dat [5];
   logic [2:0]  o_ch  [5];
   logic        o_err [5];

   assign o_rdy[0] = {1'b0, r0};  assign o_val[0] = v0; assign o_dat[0] = d0; assign o_ch[0] = {1'b0, c0}; assign o_err[0] = e0;
   assign o_rdy[1] = {2'b0, r1};  assign o_val[1] = v1; assign o_dat[1] = d1; assign o_ch[1] = {1'b0, c1}; assign o_err[1] = e1;
   assign o_rdy[2] = {1'b0, r2};  assign o_val[2] = v2; assign o_dat[2] = d2; assign o_ch[2] = {1'b0, c2}; assign o_err[2] = e2;
   assign o_rdy[3] = {1'b0, r3};  assign o_val[3] = v3; assign o_dat[3] = d3; assign o_ch[3] = {1'b0, c3}; assign o_err[3] = e3;
   assign o_rdy[4] = r4;          assign o_val[4] = v4; assign o_dat[4] = d4; assign o_ch[4] = c4;          assign o_err[4] = e4;

   int mode_t [5] = '{0, 0, 1, 2, 2};
   int nch_t  [5] = '{4, 3, 4, 4, 5};

   logic        m_val [5];
   logic [31:0] m_dat [5];
   int          m_ch  [5];
   logic        m_err [5];
   int          m_ptr [5];

   int total = 0;
   int bad   = 0;

   // Channel the rules award to instance u this cycle, or -1 for none.
   function automatic int pick(int u);
      int n;
      int s;
      int c;
      n = nch_t[u];
      if (m_val[u] && !rdy) return -1;
      if (mode_t[u] == 0) begin
         s = int'(sel) % 4;
         if (s < n && ((vin >> s) & 5'd1) != 5'd0) return s;
         return -1;
      end
      for (int off = 0; off < n; off++) begin
         c = (mode_t[u] == 1) ? off : (m_ptr[u] + off) % n;
         if (((vin >> c) & 5'd1) != 5'd0) return c;
      end
      return -1;
   endfunction

   function automatic logic [159:0] rand_din();
      logic [159:0] d;
      d = '0;
      for (int i = 0; i < 5; i++) d = {d[127:0], 32'($urandom)};
      return d;
   endfunction

   task automatic model_reset();
      for (int u = 0; u < 5; u++) begin
         m_val[u] = 1'b0; m_dat[u] = '0; m_ch[u] = 0; m_err[u] = 1'b0; m_ptr[u] = 0;
      end
   endtask

   task automatic advance();
      int   g  [5];
      logic op [5];
      logic ex [5];
      for (int u = 0; u < 5; u++) begin
         g[u]  = pick(u);
         op[u] = !m_val[u] || rdy;
         ex[u] = (mode_t[u] == 0) && op[u] && ((int'(sel) % 4) >= nch_t[u]);
      end
      @(posedge clk);
      for (int u = 0; u < 5; u++) begin
         m_err[u] = ex[u];
         if (g[u] >= 0) begin
            m_dat[u] = 32'(din >> (g[u] * 32));
            m_ch[u]  = g[u];
            m_val[u] = 1'b1;
            m_ptr[u] = (g[u] + 1) % nch_t[u];
         end else if (op[u]) begin
            m_val[u] = 1'b0;
         end
      end
   endtask

   task automatic put(input logic [4:0] v, input logic [2:0] s, input logic r, input logic [159:0] d);
      @(negedge clk);
      vin = v; sel = s; rdy = r; din = d;
      #1;
      $display("t=%0t vin=%b sel=%0d rdy=%b ready=%b/%b/%b/%b/%b ch=%0d/%0d/%0d/%0d/%0d",
               $time, vin, sel, rdy, r0, r1, r2, r3, r4, c0, c1, c2, c3, c4);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1; vin = '0; sel = '0; rdy = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      reset = 1'b1; vin = 5'b11111; sel = 3'd1; rdy = 1'b1; din = rand_din();
      #12;
      for (int u = 0; u < 5; u++) begin
         if (o_val[u] !== 1'b0 || o_dat[u] !== 32'd0 || o_ch[u] !== 3'd0 || o_err[u] !== 1'b0) begin
            bad++; $display("FAIL reset_state inst=%0d got val=%b data=%h ch=%0d err=%b want all 0", u, o_val[u], o_dat[u], o_ch[u], o_err[u]);
         end
         total++;
         if (o_rdy[u] !== 5'd0) begin
            bad++; $display("FAIL reset_ready inst=%0d got=%b want=0", u, o_rdy[u]);
         end
         total++;
      end
      @(negedge clk);
      vin = '0; sel = '0;
      reset = 1'b0;
      model_reset();
   endtask

   task automatic test_sel();
      logic [159:0] d;
      d = rand_din();
      d[95:64] = 32'hDEAD_BEEF;
      put(5'b00100, 3'd2, 1'b1, d);
      if (r0 !== 4'b0100) begin bad++; $display("FAIL sel_ready got=%b want=0100", r0); end
      total++;
      advance();
      put(5'b00000, 3'd2, 1'b1, rand_din());
      if (v0 !== 1'b1 || d0 !== 32'hDEAD_BEEF || c0 !== 2'd2) begin
         bad++; $display("FAIL sel_load got val=%b data=%h ch=%0d want 1 deadbeef 2", v0, d0, c0);
      end
      total++;
      advance();
      put(5'b00111, 3'd3, 1'b1, rand_din());
      if (r1 !== 3'b000) begin bad++; $display("FAIL sel_oor_ready got=%b want=000", r1); end
      total++;
      advance();
      put(5'b00000, 3'd0, 1'b1, rand_din());
      if (e1 !== 1'b1 || v1 !== 1'b0) begin bad++; $display("FAIL sel_oor_err got err=%b val=%b want 1 0", e1, v1); end
      total++;
      if (e0 !== 1'b0 || e2 !== 1'b0 || e3 !== 1'b0 || e4 !== 1'b0) begin
         bad++; $display("FAIL err_other got %b%b%b%b want 0000", e0, e2, e3, e4);
      end
      total++;
      advance();
      put(5'b00000, 3'd0, 1'b1, rand_din());
      if (e1 !== 1'b0) begin bad++; $display("FAIL err_pulse got=%b want=0", e1); end
      total++;
      advance();
   endtask

   task automatic test_rr_seq();
      do_reset();
      for (int k = 0; k < 6; k++) begin
         put(5'b01111, 3'd0, 1'b1, rand_din());
         if (k > 0) begin
            if (v3 !== 1'b1 || c3 !== 2'((k - 1) % 4)) begin
               bad++; $display("FAIL rr_seq step=%0d got val=%b ch=%0d want 1 %0d", k, v3, c3, (k - 1) % 4);
            end
            total++;
         end
         if (k < 5) begin
            if (r3 !== 4'(1 << (k % 4))) begin
               bad++; $display("FAIL rr_ready step=%0d got=%b want=%b", k, r3, 4'(1 << (k % 4)));
            end
            total++;
            advance();
         end
      end
   endtask

   task automatic test_prio_stall();
      logic [159:0] d;
      logic [31:0]  first;
      do_reset();
      d = rand_din();
      first = d[63:32];
      put(5'b01010, 3'd0, 1'b1, d);
      if (r2 !== 4'b0010) begin bad++; $display("FAIL prio_ready got=%b want=0010", r2); end
      total++;
      advance();
      for (int k = 0; k < 3; k++) begin
         put(5'b01010, 3'd0, 1'b0, rand_din());
         if (v2 !== 1'b1 || c2 !== 2'd1 || d2 !== first || r2 !== 4'b0000) begin
            bad++; $display("FAIL prio_stall cyc=%0d got val=%b ch=%0d data=%h ready=%b want 1 1 %h 0000", k, v2, c2, d2, r2, first);
         end
         total++;
         advance();
      end
      put(5'b01010, 3'd0, 1'b1, rand_din());
      if (r2 !== 4'b0010) begin bad++; $display("FAIL prio_release got=%b want=0010", r2); end
      total++;
      advance();
      put(5'b01000, 3'd0, 1'b1, rand_din());
      if (c2 !== 2'd1 || r2 !== 4'b1000) begin bad++; $display("FAIL prio_again got ch=%0d ready=%b want 1 1000", c2, r2); end
      total++;
      advance();
      put(5'b00000, 3'd0, 1'b1, rand_din());
      if (v2 !== 1'b1 || c2 !== 2'd3) begin bad++; $display("FAIL prio_next got val=%b ch=%0d want 1 3", v2, c2); end
      total++;
      advance();
   endtask

   task automatic test_rr5_wrap();
      int exp_ch [3] = '{4, 0, 4};
      do_reset();
      put(5'b01000, 3'd0, 1'b1, rand_din());
      if (r4 !== 5'b01000) begin bad++; $display("FAIL rr5_first got=%b want=01000", r4); end
      total++;
      advance();
      for (int k = 0; k < 3; k++) begin
         put(5'b10001, 3'd0, 1'b1, rand_din());
         if (r4 !== 5'(1 << exp_ch[k])) begin
            bad++; $display("FAIL rr5_ready step=%0d got=%b want=%b", k, r4, 5'(1 << exp_ch[k]));
         end
         total++;
         advance();
         #1;
         if (c4 !== 3'(exp_ch[k])) begin bad++; $display("FAIL rr5_ch step=%0d got=%0d want=%0d", k, c4, exp_ch[k]); end
         total++;
      end
   endtask

   task automatic test_async_reset();
      logic [159:0] d;
      do_reset();
      d = rand_din();
      d[63:32] = 32'h1234_5678;
      put(5'b00010, 3'd0, 1'b1, d);
      advance();
      put(5'b00000, 3'd0, 1'b0, rand_din());
      if (v3 !== 1'b1 || d3 !== 32'h1234_5678) begin bad++; $display("FAIL pre_reset got val=%b data=%h want 1 12345678", v3, d3); end
      total++;
      #2;
      reset = 1'b1;
      #1;
      if (v3 !== 1'b0 || d3 !== 32'd0 || c3 !== 2'd0 || r3 !== 4'd0) begin
         bad++; $display("FAIL async_reset got val=%b data=%h ch=%0d ready=%b want 0 0 0 0", v3, d3, c3, r3);
      end
      total++;
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      put(5'b01111, 3'd0, 1'b1, rand_din());
      if (r3 !== 4'b0001) begin bad++; $display("FAIL post_reset_grant got=%b want=0001", r3); end
      total++;
      advance();
      put(5'b00000, 3'd0, 1'b1, rand_din());
      if (v3 !== 1'b1 || c3 !== 2'd0) begin bad++; $display("FAIL post_reset_ch got val=%b ch=%0d want 1 0", v3, c3); end
      total++;
      advance();
   endtask

   task automatic test_random();
      int         g;
      logic [4:0] er;
      do_reset();
      for (int n = 0; n < 200; n++) begin
         put(5'($urandom), 3'($urandom_range(0, 7)), ($urandom % 4) != 0, rand_din());
         for (int u = 0; u < 5; u++) begin
            g  = pick(u);
            er = (g >= 0) ? 5'(1 << g) : 5'd0;
            if (o_rdy[u] !== er) begin bad++; $display("FAIL rnd_ready n=%0d inst=%0d got=%b want=%b", n, u, o_rdy[u], er); end
            if (o_val[u] !== m_val[u]) begin bad++; $display("FAIL rnd_valid n=%0d inst=%0d got=%b want=%b", n, u, o_val[u], m_val[u]); end
            if (o_dat[u] !== m_dat[u]) begin bad++; $display("FAIL rnd_data n=%0d inst=%0d got=%h want=%h", n, u, o_dat[u], m_dat[u]); end
            if (o_ch[u] !== 3'(m_ch[u])) begin bad++; $display("FAIL rnd_ch n=%0d inst=%0d got=%0d want=%0d", n, u, o_ch[u], m_ch[u]); end
            if (o_err[u] !== m_err[u]) begin bad++; $display("FAIL rnd_err n=%0d inst=%0d got=%b want=%b", n, u, o_err[u], m_err[u]); end
            total += 5;
         end
         advance();
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_sel();
      test_rr_seq();
      test_prio_stall();
      test_rr5_wrap();
      test_async_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/arb_mux.md
ARB_MUX -- requirements
Module: arb_mux

Interface
REQ-001 SHALL provide parameter WIDTH, default 32: data width per channel, 1..64.
REQ-002 SHALL provide parameter NCH, default 4: input channel count, 2..16.
REQ-003 SHALL provide parameter MODE, default 0: 0 = explicit select, 1 = fixed priority (lowest index wins), 2 = round-robin.
REQ-004 SHALL derive localparam SELW = max(1, clog2(NCH)).
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 in_valid  in  NCH  per-channel data valid.
REQ-008 in_ready  out  NCH  per-channel accept; at most one bit high.
REQ-009 in_data  in  NCH*WIDTH  packed channel data; channel i at bits [i*WIDTH +: WIDTH].
REQ-010 sel  in  SELW  channel select, used only in MODE 0.
REQ-011 out_valid  out  1  output register holds valid data.
REQ-012 out_ready  in  1  downstream accept.
REQ-013 out_data  out  WIDTH  registered selected data.
REQ-014 out_ch  out  SELW  index of the channel that supplied out_data.
REQ-015 err_sel  out  1  one-cycle registered pulse: out-of-range select seen.

Function
REQ-016 Stage "open" = !out_valid || out_ready; grant only while open.
REQ-017 MODE 0: grant channel sel when open, sel < NCH, and in_valid[sel]=1; otherwise no grant.
REQ-018 MODE 1: grant lowest-index i with in_valid[i]=1 when open.
REQ-019 MODE 2: grant first in_valid channel searching from pointer rr_ptr upward, wrapping NCH-1 -> 0.
REQ-020 in_ready SHALL equal the one-hot grant vector, combinational from in_valid, sel, rr_ptr, out_valid, out_ready.
REQ-021 On a grant to channel k: next edge loads out_data = in_data[k], out_ch = k, out_valid = 1; latency exactly 1 cycle.
REQ-022 Open with no grant: next edge clears out_valid; out_data and out_ch hold.
REQ-023 out_valid=1 and out_ready=0: out_data, out_ch, out_valid SHALL hold unchanged; in_ready all 0.
REQ-024 Full throughput: simultaneous downstream pop and upstream grant in one cycle SHALL sustain one transfer per cycle.
REQ-025 rr_ptr SHALL update to (k+1) mod NCH only on a grant to k; no grant leaves it unchanged; non-power-of-two NCH wraps at NCH-1.
REQ-026 err_sel SHALL be 1 on the edge after any cycle with MODE 0, stage open, sel >= NCH; else 0; never asserts in MODES 1/2 or when NCH is a power of two.
REQ-027 A channel's in_valid SHALL not be required to persist; dropping it before grant causes no transfer.

Reset
REQ-028 Reset asserted SHALL immediately force out_valid=0, out_data=0, out_ch=0, err_sel=0, rr_ptr=0, independent of clk.
REQ-029 in_ready SHALL be all 0 while reset is asserted.
REQ-030 Reset mid-transfer SHALL discard held data; first grant after release follows REQ-017..019 with rr_ptr=0.

Structure
REQ-031 Mode encodings (MODE_SEL=0, MODE_PRIO=1, MODE_RR=2) SHALL live in shared package mux_pkg, alongside the clog2-based SELW helper.
REQ-032 Arbitration SHALL be one sub-module rr_arbiter (request vector, pointer, open -> one-hot grant, encoded index); MODE 1 uses it with pointer tied 0.
REQ-033 Output register and rr_ptr SHALL reside in arb_mux; no other storage.

Verification
REQ-034 MODE 0, NCH=4, sel=2, in_valid=4'b0100, in_data[2]=32'hDEAD_BEEF, out_ready=1 -> in_ready=4'b0100; next cycle out_valid=1, out_data=32'hDEAD_BEEF, out_ch=2.
REQ-035 MODE 0, NCH=3, sel=3 -> in_ready=0, err_sel=1 next cycle, out_valid=0.
REQ-036 MODE 2, NCH=4, in_valid=4'b1111 held, out_ready=1 -> out_ch sequence 0,1,2,3,0 over five cycles.
REQ-037 MODE 1, in_valid=4'b1010, out_ready=0 after first load -> out_ch=1 held stable, in_ready=0 for all stalled cycles; release -> out_ch=1 again next, then 3 only when in_valid[1] drops.
REQ-038 MODE 2, NCH=5, in_valid=5'b10001, rr_ptr=4 -> grants 4, then 0, then 4.
REQ-039 Reset asserted between edges while out_valid=1 -> out_valid=0 and out_data=0 immediately; after release in MODE 2 first grant from channel 0 upward.
